// File: rtl/full_adder_pkg.sv
// Shared constants for the full adder: default counter width and the
// reference truth table, indexed by {a,b,cin} and holding {sum,cout}.
package full_adder_pkg;

  localparam int CNT_W_DEFAULT = 16;

  // Entry i occupies bits [2*i+1:2*i] and is {sum,cout} for {a,b,cin} == i.
  localparam logic [15:0] FA_TRUTH = 16'b11_01_01_10_01_10_10_00;

  function automatic logic [1:0] fa_expect(input logic [2:0] abc);
    logic [3:0] idx;
    idx = {abc, 1'b0};
    return FA_TRUTH[idx +: 2];
  endfunction

endpackage

// File: rtl/half_adder.sv
// Two-input half adder: sum and carry of a single bit pair.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder with a combinational result, a valid-qualified
// registered copy, and wrapping operation/carry statistics counters.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             sum,
  output logic             cout,
  output logic             sum_q,
  output logic             cout_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] carry_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic ha0_sum, ha0_carry;
  logic ha1_sum, ha1_carry;

  logic             sum_r_d, sum_r_q;
  logic             cout_r_d, cout_r_q;
  logic             out_valid_d, out_valid_q;
  logic [CNT_W-1:0] op_count_d, op_count_q;
  logic [CNT_W-1:0] carry_count_d, carry_count_q;

  half_adder u_ha0 (.a(a),       .b(b),   .s(ha0_sum), .c(ha0_carry));
  half_adder u_ha1 (.a(ha0_sum), .b(cin), .s(ha1_sum), .c(ha1_carry));

  assign sum  = ha1_sum;
  assign cout = ha0_carry | ha1_carry;

  // Next-state: capture and count only on qualified cycles, otherwise hold.
  always_comb begin
    sum_r_d       = sum_r_q;
    cout_r_d      = cout_r_q;
    out_valid_d   = in_valid;
    op_count_d    = op_count_q;
    carry_count_d = carry_count_q;
    if (in_valid) begin
      sum_r_d    = sum;
      cout_r_d   = cout;
      op_count_d = op_count_q + CNT_ONE;
      if (cout) begin
        carry_count_d = carry_count_q + CNT_ONE;
      end else begin
        carry_count_d = carry_count_q;
      end
    end else begin
      op_count_d = op_count_q;
    end
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r_q       <= 1'b0;
      cout_r_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      op_count_q    <= {CNT_W{1'b0}};
      carry_count_q <= {CNT_W{1'b0}};
    end else begin
      sum_r_q       <= sum_r_d;
      cout_r_q      <= cout_r_d;
      out_valid_q   <= out_valid_d;
      op_count_q    <= op_count_d;
      carry_count_q <= carry_count_d;
    end
  end

  assign sum_q       = sum_r_q;
  assign cout_q      = cout_r_q;
  assign out_valid   = out_valid_q;
  assign op_count    = op_count_q;
  assign carry_count = carry_count_q;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: stimulus queues expected registered
// results, a monitor pops them whenever out_valid is seen.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst;
  logic a, b, cin, in_valid;
  logic sum, cout, sum_q, cout_q, out_valid;
  logic [15:0] op_count, carry_count;
  logic sum4, cout4, sum_q4, cout_q4, out_valid4;
  logic [3:0] op_count4, carry_count4;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] sb_q[$];
  logic [1:0] exp_hold = 2'b00;
  int exp_ops = 0;
  int exp_carry = 0;

  // {a,b,cin,sum,cout}, hand-computed, sweep order 000,010,100,110,001,011,101,111
  logic [4:0] vec [8] = '{5'b000_0_0, 5'b010_1_0, 5'b100_1_0, 5'b110_0_1,
                          5'b001_1_0, 5'b011_0_1, 5'b101_0_1, 5'b111_1_1};

  full_adder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum), .cout(cout), .sum_q(sum_q), .cout_q(cout_q),
    .out_valid(out_valid), .op_count(op_count), .carry_count(carry_count)
  );

  full_adder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum4), .cout(cout4), .sum_q(sum_q4), .cout_q(cout_q4),
    .out_valid(out_valid4), .op_count(op_count4), .carry_count(carry_count4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] v, input logic valid);
    a = v[4]; b = v[3]; cin = v[2]; in_valid = valid;
    if (valid && !rst) begin
      sb_q.push_back(v[1:0]);
      exp_ops++;
      if (v[0]) exp_carry++;
    end
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, " sum_q"}, {31'd0, sum_q}, 32'd0);
    check({tag, " cout_q"}, {31'd0, cout_q}, 32'd0);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " op_count"}, {16'd0, op_count}, 32'd0);
    check({tag, " carry_count"}, {16'd0, carry_count}, 32'd0);
    check({tag, " op_count4"}, {28'd0, op_count4}, 32'd0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, " op_count"}, {16'd0, op_count}, exp_ops & 32'hFFFF);
    check({tag, " carry_count"}, {16'd0, carry_count}, exp_carry & 32'hFFFF);
    check({tag, " op_count4"}, {28'd0, op_count4}, exp_ops & 32'hF);
    check({tag, " carry_count4"}, {28'd0, carry_count4}, exp_carry & 32'hF);
  endtask

  // Monitor: one sample per edge, pops the scoreboard when out_valid is seen.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        sb_q.delete();
        exp_hold = 2'b00;
        check("mon rst out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        check("mon out_valid", {31'd0, out_valid}, {31'd0, in_valid});
        if (out_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            check("mon scoreboard empty", 32'd1, 32'd0);
          end else begin
            exp_hold = sb_q.pop_front();
          end
        end
        check("mon sum_q/cout_q", {30'd0, sum_q, cout_q}, {30'd0, exp_hold});
        check("mon sum_q4/cout_q4", {30'd0, sum_q4, cout_q4}, {30'd0, exp_hold});
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(5'b000_0_0, 1'b0);
    @(negedge clk);
    check_regs_zero("reset");

    // Combinational sweep while held in reset, 5 time units apart.
    for (int i = 0; i < 8; i++) begin
      drive(vec[i], 1'b0);
      #5;
      check($sformatf("comb sum %0d", i), {31'd0, sum}, {31'd0, vec[i][1]});
      check($sformatf("comb cout %0d", i), {31'd0, cout}, {31'd0, vec[i][0]});
    end
    check_regs_zero("reset hold");

    // Valid cycles overlapping reset are discarded.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(5'b111_1_1, 1'b1);
      @(negedge clk);
    end
    drive(5'b000_0_0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("overlap op_count", {16'd0, op_count}, 32'd0);
    check("overlap out_valid", {31'd0, out_valid}, 32'd0);

    // Full sweep with in_valid: 8 operations, 4 carries.
    for (int i = 0; i < 8; i++) begin
      drive(vec[i], 1'b1);
      @(negedge clk);
    end
    drive(5'b000_0_0, 1'b0);
    @(negedge clk);
    check_counts("sweep");
    check("sweep op_count=8", {16'd0, op_count}, 32'd8);
    check("sweep carry_count=4", {16'd0, carry_count}, 32'd4);

    // Registered path: capture 111, then hold with differing inputs.
    drive(5'b111_1_1, 1'b1);
    @(negedge clk);
    check("reg sum_q", {31'd0, sum_q}, 32'd1);
    check("reg cout_q", {31'd0, cout_q}, 32'd1);
    drive(5'b000_0_0, 1'b0);
    @(negedge clk);
    check("hold sum_q", {31'd0, sum_q}, 32'd1);
    check("hold cout_q", {31'd0, cout_q}, 32'd1);
    check_counts("hold");

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check_regs_zero("async");
    drive(5'b100_1_0, 1'b0);
    #1;
    check("async comb sum", {31'd0, sum}, 32'd1);
    check("async comb cout", {31'd0, cout}, 32'd0);
    exp_ops = 0;
    exp_carry = 0;
    @(negedge clk);
    rst = 1'b0;
    drive(5'b000_0_0, 1'b0);
    @(negedge clk);

    // Wrap: 16 operations of 1+1+0 roll the 4-bit counters back to zero.
    for (int i = 0; i < 16; i++) begin
      drive(5'b110_0_1, 1'b1);
      @(negedge clk);
    end
    drive(5'b000_0_0, 1'b0);
    @(negedge clk);
    check_counts("wrap");
    check("wrap op_count4=0", {28'd0, op_count4}, 32'd0);
    check("wrap carry_count4=0", {28'd0, carry_count4}, 32'd0);
    check("wrap op_count=16", {16'd0, op_count}, 32'd16);

    @(negedge clk);
    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
